// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: opcode constants, FSM state encoding, arbitration helper.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package alu_sched_pkg;

    // Opcodes understood by the downstream ALU; anything above OP_MAX is rejected.
    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_MUL = 6'd2;
    localparam logic [5:0] OP_DIV = 6'd3;
    localparam logic [5:0] OP_AND = 6'd4;
    localparam logic [5:0] OP_OR  = 6'd5;
    localparam logic [5:0] OP_XOR = 6'd6;
    localparam logic [5:0] OP_SHL = 6'd7;
    localparam logic [5:0] OP_CMP = 6'd8;
    localparam logic [5:0] OP_MAX = 6'd8;

    // Wait counter width: latencies up to 15 cycles.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Opcode outside the supported set.
    function automatic logic op_illegal(input logic [5:0] op);
        return (op > OP_MAX);
    endfunction

    // Winner of a 2-way request: the priority holder if it asks, else the other one.
    function automatic logic arb_pick(input logic [1:0] vld, input logic prio);
        return vld[prio] ? prio : ~prio;
    endfunction

endpackage

// File: rtl/alu_sched_arb.sv
// 2-way requester arbiter with a priority pointer; round-robin when ALU_SCHED_RR_EN is defined, else requester 0 always wins.
// Latency: grant is combinational from valid; the pointer updates on the accepting edge.
// Backpressure: grants nothing while en_i is low, so requests simply stall.
module alu_sched_arb
    import alu_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_vld_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic prio_q;
    logic prio_d;

    // Combinational winner and one-hot grant, gated by the enable.
    always_comb begin
        gnt_id_o = arb_pick(req_vld_i, prio_q);
        gnt_o    = 2'b00;
        if (en_i && (|req_vld_i)) begin
            gnt_o = gnt_id_o ? 2'b10 : 2'b01;
        end
    end

    // Pointer next state: hand priority to the loser, or pin it to requester 0.
    always_comb begin
`ifdef ALU_SCHED_RR_EN
        prio_d = accept_i ? ~gnt_id_o : prio_q;
`else
        prio_d = accept_i ? 1'b0 : prio_q;
`endif
    end

    // Pointer register; reset points priority at requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external ALU between two requesters, one operation in flight; optional ALU_SCHED_RR_EN selects round-robin.
// Latency: response LAT (LAT_DIV for divide) edges after acceptance; illegal op / divide-by-zero respond on the acceptance edge.
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready, requests stall meanwhile.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int LAT     = 1,
    parameter int LAT_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [11:0] req_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [5:0]  alu_op,
    input  logic [7:0]  alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic        rsp_err
);

    localparam logic [CNT_W-1:0] LAT_CNT     = LAT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LAT_DIV_CNT = LAT_DIV[CNT_W-1:0];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [5:0]       alu_op_q, alu_op_d;
    logic             rsp_id_q, rsp_id_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic [1:0] gnt;
    logic       gnt_id;
    logic       accept;
    logic       in_idle;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic [5:0] sel_op;
    logic       sel_div;
    logic       sel_bad_op;
    logic       sel_err;

    assign in_idle = (state_q == ST_IDLE);
    assign accept  = |(req_valid & req_ready);

    alu_sched_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .en_i      (in_idle),
        .req_vld_i (req_valid),
        .accept_i  (accept),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id)
    );

    // Pick the granted requester's lane and classify its opcode.
    always_comb begin
        sel_a      = gnt_id ? req_a[15:8]  : req_a[7:0];
        sel_b      = gnt_id ? req_b[15:8]  : req_b[7:0];
        sel_op     = gnt_id ? req_op[11:6] : req_op[5:0];
        sel_div    = (sel_op == OP_DIV);
        sel_bad_op = op_illegal(sel_op);
        sel_err    = sel_bad_op || (sel_div && (sel_b == 8'h00));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: errors skip WAIT, the counter expiring ends WAIT, rsp_ready ends RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = sel_err ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: grants only while idle, response valid only in RESP.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 1'b0;
        if (state_q == ST_IDLE) begin
            req_ready = gnt;
        end
        if (state_q == ST_RESP) begin
            rsp_valid = 1'b1;
        end
    end

    // Datapath next state: launch on accept, count down in WAIT, capture the result on the last count.
    always_comb begin
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    alu_a_d   = sel_a;
                    alu_b_d   = sel_b;
                    alu_op_d  = sel_op;
                    rsp_id_d  = gnt_id;
                    cnt_d     = sel_div ? LAT_DIV_CNT : LAT_CNT;
                    rsp_err_d = sel_err;
                    // Illegal opcode reports 00, divide by zero reports FF.
                    if (sel_err) begin
                        rsp_data_d = sel_bad_op ? 8'h00 : 8'hFF;
                    end else begin
                        rsp_data_d = 8'h00;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= 1) begin
                    rsp_data_d = alu_result;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            alu_a_q    <= 8'h00;
            alu_b_q    <= 8'h00;
            alu_op_q   <= 6'h00;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule
